// File: rtl/hazard5_rvfi_trace_buffer.sv
// hazard5_rvfi_trace_buffer
//   Purpose : circular trace of RVFI retirements around a trigger (pre-trigger history
//             plus POST_TRIG post-trigger records), drained oldest-first once DONE.
//   Latency : capture is registered (one entry per retiring cycle); readout is
//             combinational from state/count/storage (zero read latency).
//   Backpressure: the drain port holds rd_data_o stable while rd_ready_i is low; the
//             RVFI side is never stalled (retirements outside ARMED/POST are dropped).
//   Ports   : clock_i/reset_i (sync, active-high); rvfi_*_i retirement stream;
//             arm_i pulse, trig_pc_i, trig_on_trap_i trigger control;
//             rd_valid_o/rd_ready_i/rd_data_o drain port;
//             state_o (0 IDLE,1 ARMED,2 POST,3 DONE), count_o entries held.
//   rd_data_o layout: {trig, discont, trap, rd_addr[4:0], rd_wdata, insn, pc}.
module hazard5_rvfi_trace_buffer #(
  parameter int DEPTH_LOG2 = 6,
  parameter int POST_TRIG  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  rvfi_valid_i,
  input  logic [31:0]           rvfi_insn_i,
  input  logic [31:0]           rvfi_pc_rdata_i,
  input  logic [31:0]           rvfi_pc_wdata_i,
  input  logic                  rvfi_trap_i,
  input  logic [4:0]            rvfi_rd_addr_i,
  input  logic [31:0]           rvfi_rd_wdata_i,
  input  logic                  arm_i,
  input  logic [31:0]           trig_pc_i,
  input  logic                  trig_on_trap_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [103:0]          rd_data_o,
  output logic [1:0]            state_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 104;
  localparam int CW      = DEPTH_LOG2 + 1;
  // post_ctr must hold POST_TRIG; keep at least one bit when POST_TRIG is 0
  localparam int PW      = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         post_ctr_q, post_ctr_d;
  logic [31:0]           last_npc_q, last_npc_d;
  logic                  first_q, first_d;

  logic [ENTRY_W-1:0]    mem [DEPTH];

  logic                  capture;
  logic                  hit;
  logic                  entry_trig;
  logic                  entry_discont;
  logic [ENTRY_W-1:0]    entry;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign capture = rvfi_valid_i && (state_q == ARMED || state_q == POST) && !arm_i;
  assign hit     = (rvfi_pc_rdata_i == trig_pc_i) || (trig_on_trap_i && rvfi_trap_i);

  // Only the record that moves ARMED -> POST/DONE carries the trigger flag
  assign entry_trig    = (state_q == ARMED) && hit;
  assign entry_discont = first_q || (rvfi_pc_rdata_i != last_npc_q);
  assign entry = {entry_trig, entry_discont, rvfi_trap_i, rvfi_rd_addr_i,
                  rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i};

  // Oldest entry sits count slots behind wptr. When full, count's low bits are
  // zero so this lands on wptr itself, which is the oldest after a wrap.
  assign rd_idx     = wptr_q - count_q[DEPTH_LOG2-1:0];
  assign rd_valid_o = (state_q == DONE) && (count_q != '0);
  assign rd_data_o  = mem[rd_idx];
  assign state_o    = state_q;
  assign count_o    = count_q;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    post_ctr_d = post_ctr_q;
    last_npc_d = last_npc_q;
    first_d    = first_q;

    if (arm_i) begin
      state_d    = ARMED;
      wptr_d     = '0;
      count_d    = '0;
      post_ctr_d = '0;
      first_d    = 1'b1;
    end else begin
      if (capture) begin
        wptr_d     = wptr_q + 1'b1;
        last_npc_d = rvfi_pc_wdata_i;
        first_d    = 1'b0;
        if (count_q != CW'(DEPTH)) begin
          count_d = count_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
        end
        ARMED: begin
          if (capture && hit) begin
            post_ctr_d = PW'(POST_TRIG);
            state_d    = (POST_TRIG == 0) ? DONE : POST;
          end
        end
        POST: begin
          if (capture) begin
            post_ctr_d = post_ctr_q - 1'b1;
            if (post_ctr_q == PW'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (rd_valid_o && rd_ready_i) begin
            count_d = count_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      post_ctr_q <= '0;
      last_npc_q <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      post_ctr_q <= post_ctr_d;
      last_npc_q <= last_npc_d;
      first_q    <= first_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clock_i) begin
    if (capture && !reset_i) begin
      mem[wptr_q] <= entry;
    end
  end

endmodule

// File: tb/tb_hazard5_rvfi_trace_buffer.sv
// tb_hazard5_rvfi_trace_buffer
//   Purpose : directed checks of the trace buffer using three instances sharing one
//             stimulus: A (POST_TRIG=2), B (POST_TRIG=16), C (POST_TRIG=0), DEPTH=64.
//   Timing  : inputs change and outputs are sampled 1ns after each rising edge.
module tb_hazard5_rvfi_trace_buffer;

  logic        clk;
  logic        rst;
  logic        rvfi_valid;
  logic [31:0] rvfi_insn;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic        rvfi_trap;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        arm;
  logic [31:0] trig_pc;
  logic        trig_on_trap;
  logic        rd_ready;

  logic         rd_valid_a, rd_valid_b, rd_valid_c;
  logic [103:0] rd_data_a, rd_data_b, rd_data_c;
  logic [1:0]   state_a, state_b, state_c;
  logic [6:0]   count_a, count_b, count_c;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard5_rvfi_trace_buffer #(.DEPTH_LOG2(6), .POST_TRIG(2)) u_a (
    .clock_i(clk), .reset_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_insn_i(rvfi_insn),
    .rvfi_pc_rdata_i(rvfi_pc_rdata), .rvfi_pc_wdata_i(rvfi_pc_wdata),
    .rvfi_trap_i(rvfi_trap), .rvfi_rd_addr_i(rvfi_rd_addr), .rvfi_rd_wdata_i(rvfi_rd_wdata),
    .arm_i(arm), .trig_pc_i(trig_pc), .trig_on_trap_i(trig_on_trap),
    .rd_valid_o(rd_valid_a), .rd_ready_i(rd_ready), .rd_data_o(rd_data_a),
    .state_o(state_a), .count_o(count_a));

  hazard5_rvfi_trace_buffer #(.DEPTH_LOG2(6), .POST_TRIG(16)) u_b (
    .clock_i(clk), .reset_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_insn_i(rvfi_insn),
    .rvfi_pc_rdata_i(rvfi_pc_rdata), .rvfi_pc_wdata_i(rvfi_pc_wdata),
    .rvfi_trap_i(rvfi_trap), .rvfi_rd_addr_i(rvfi_rd_addr), .rvfi_rd_wdata_i(rvfi_rd_wdata),
    .arm_i(arm), .trig_pc_i(trig_pc), .trig_on_trap_i(trig_on_trap),
    .rd_valid_o(rd_valid_b), .rd_ready_i(rd_ready), .rd_data_o(rd_data_b),
    .state_o(state_b), .count_o(count_b));

  hazard5_rvfi_trace_buffer #(.DEPTH_LOG2(6), .POST_TRIG(0)) u_c (
    .clock_i(clk), .reset_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_insn_i(rvfi_insn),
    .rvfi_pc_rdata_i(rvfi_pc_rdata), .rvfi_pc_wdata_i(rvfi_pc_wdata),
    .rvfi_trap_i(rvfi_trap), .rvfi_rd_addr_i(rvfi_rd_addr), .rvfi_rd_wdata_i(rvfi_rd_wdata),
    .arm_i(arm), .trig_pc_i(trig_pc), .trig_on_trap_i(trig_on_trap),
    .rd_valid_o(rd_valid_c), .rd_ready_i(rd_ready), .rd_data_o(rd_data_c),
    .state_o(state_c), .count_o(count_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One retirement cycle; side-band fields derived from pc so entries are distinguishable
  task automatic retire(input logic [31:0] pc, input logic [31:0] npc, input logic trap);
    rvfi_valid    = 1'b1;
    rvfi_pc_rdata = pc;
    rvfi_pc_wdata = npc;
    rvfi_insn     = pc ^ 32'h0000_0013;
    rvfi_rd_addr  = pc[6:2];
    rvfi_rd_wdata = ~pc;
    rvfi_trap     = trap;
    tick();
    rvfi_valid    = 1'b0;
    rvfi_trap     = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1; rvfi_valid = 1'b0; rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    rvfi_trap = 1'b0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0; arm = 1'b0;
    trig_pc = 32'h10; trig_on_trap = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state; retirements ignored in IDLE
    chk("rst_state", 64'(state_a), 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);
    chk("rst_rdvld", 64'(rd_valid_a), 64'd0);
    retire(32'h0, 32'h4, 1'b0);
    chk("idle_count", 64'(count_a), 64'd0);

    // Test 1: PCs 0x0..0x18, trigger at 0x10, POST_TRIG=2
    do_arm();
    chk("t1_armed", 64'(state_a), 64'd1);
    for (int i = 0; i < 7; i++) begin
      retire(32'(4 * i), 32'(4 * i + 4), 1'b0);
      if (i == 4) chk("t1_post", 64'(state_a), 64'd2);
    end
    chk("t1_done", 64'(state_a), 64'd3);
    chk("t1_count", 64'(count_a), 64'd7);
    chk("t1_insn0", 64'(rd_data_a[63:32]), 64'h13);
    chk("t1_wdat0", 64'(rd_data_a[95:64]), 64'hFFFF_FFFF);
    rd_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t1_vld", 64'(rd_valid_a), 64'd1);
      chk("t1_pc", 64'(rd_data_a[31:0]), 64'(4 * i));
      chk("t1_trig", 64'(rd_data_a[103]), (i == 4) ? 64'd1 : 64'd0);
      chk("t1_disc", 64'(rd_data_a[102]), (i == 0) ? 64'd1 : 64'd0);
      chk("t1_rdad", 64'(rd_data_a[100:96]), 64'(i % 32));
      tick();
    end
    rd_ready = 1'b0;
    chk("t1_empty_vld", 64'(rd_valid_a), 64'd0);
    chk("t1_empty_cnt", 64'(count_a), 64'd0);
    chk("t1_empty_st", 64'(state_a), 64'd3);

    // Test 2: 100 pre-trigger + trigger + 16 post into DEPTH=64 (instance B)
    trig_pc = 32'h1190;
    do_arm();
    for (int i = 0; i < 117; i++) retire(32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i), 1'b0);
    chk("t2_done", 64'(state_b), 64'd3);
    chk("t2_count", 64'(count_b), 64'd64);
    rd_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk("t2_pc", 64'(rd_data_b[31:0]), 64'(32'h1000 + 32'(4 * (53 + k))));
      chk("t2_trig", 64'(rd_data_b[103]), (k == 47) ? 64'd1 : 64'd0);
      tick();
    end
    rd_ready = 1'b0;
    chk("t2_empty", 64'(rd_valid_b), 64'd0);

    // Test 3 + 5: discontinuity, stall, arm with a coincident retirement (instance A)
    trig_pc = 32'h200;
    do_arm();
    retire(32'h20,  32'h100, 1'b0);
    retire(32'h100, 32'h104, 1'b0);
    retire(32'h200, 32'h204, 1'b0);
    retire(32'h204, 32'h208, 1'b0);
    retire(32'h208, 32'h20C, 1'b0);
    chk("t3_done", 64'(state_a), 64'd3);
    chk("t3_count", 64'(count_a), 64'd5);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_hold_cnt", 64'(count_a), 64'd5);
    chk("t5_hold_pc", 64'(rd_data_a[31:0]), 64'h20);
    rd_ready = 1'b1;
    chk("t3_disc0", 64'(rd_data_a[102]), 64'd1);
    tick();
    chk("t3_pc1", 64'(rd_data_a[31:0]), 64'h100);
    chk("t3_disc1", 64'(rd_data_a[102]), 64'd0);
    tick();
    rd_ready = 1'b0;
    chk("t3_pc2", 64'(rd_data_a[31:0]), 64'h200);
    chk("t3_disc2", 64'(rd_data_a[102]), 64'd1);
    chk("t3_trig2", 64'(rd_data_a[103]), 64'd1);
    chk("t3_cnt2", 64'(count_a), 64'd3);
    trig_pc = 32'h304;
    arm = 1'b1; rd_ready = 1'b1;
    retire(32'h300, 32'h304, 1'b0);
    arm = 1'b0; rd_ready = 1'b0;
    chk("t5_arm_st", 64'(state_a), 64'd1);
    chk("t5_arm_cnt", 64'(count_a), 64'd0);
    tick();
    chk("t5_arm_cnt2", 64'(count_a), 64'd0);
    retire(32'h304, 32'h308, 1'b0);
    retire(32'h308, 32'h30C, 1'b0);
    retire(32'h30C, 32'h310, 1'b0);
    chk("t5_cnt", 64'(count_a), 64'd3);
    chk("t5_first_pc", 64'(rd_data_a[31:0]), 64'h304);
    chk("t5_first_disc", 64'(rd_data_a[102]), 64'd1);

    // Test 4: trap trigger with POST_TRIG=0 (instance C)
    trig_pc = 32'hFFFF_FFF0; trig_on_trap = 1'b1;
    do_arm();
    retire(32'h40, 32'h44, 1'b0);
    chk("t4_armed", 64'(state_c), 64'd1);
    retire(32'h44, 32'h48, 1'b1);
    chk("t4_done", 64'(state_c), 64'd3);
    chk("t4_count", 64'(count_c), 64'd2);
    chk("t4_pc0", 64'(rd_data_c[31:0]), 64'h40);
    chk("t4_trig0", 64'(rd_data_c[103]), 64'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t4_pc1", 64'(rd_data_c[31:0]), 64'h44);
    chk("t4_trap1", 64'(rd_data_c[101]), 64'd1);
    chk("t4_trig1", 64'(rd_data_c[103]), 64'd1);
    trig_on_trap = 1'b0;

    // Test 6: reset mid-POST (instance A)
    trig_pc = 32'h500;
    do_arm();
    retire(32'h500, 32'h504, 1'b0);
    retire(32'h504, 32'h508, 1'b0);
    chk("t6_post", 64'(state_a), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_st", 64'(state_a), 64'd0);
    chk("t6_cnt", 64'(count_a), 64'd0);
    chk("t6_vld", 64'(rd_valid_a), 64'd0);
    pc = 32'h600;
    retire(pc, pc + 32'd4, 1'b0);
    retire(pc + 32'd4, pc + 32'd8, 1'b0);
    chk("t6_idle_st", 64'(state_a), 64'd0);
    chk("t6_idle_cnt", 64'(count_a), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
